// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
//   master : used by if_stage. It takes in the hazard controls, the branch target and
//            instr_in, and it drives instr_addr, pc_out and the IF/ID register outputs.
//   slave  : used by the surrounding pipeline or test environment. It is the mirror image
//            of master.
interface if_stage_if;
   logic        stall;
   logic        flush;
   logic        pc_src;
   logic [31:0] branch_target;
   logic [31:0] instr_addr;
   logic [31:0] instr_in;
   logic [31:0] pc_out;
   logic [31:0] ifid_npc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

   modport master (
      input  stall, flush, pc_src, branch_target, instr_in,
      output instr_addr, pc_out, ifid_npc, ifid_instr, ifid_valid
   );

   modport slave (
      output stall, flush, pc_src, branch_target, instr_in,
      input  instr_addr, pc_out, ifid_npc, ifid_instr, ifid_valid
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC and forms PC+PC_STEP. It then selects the next PC, which is either the
// sequential PC or a word-aligned branch/jump target. It also loads the IF/ID register
// with the fetched word and its PC+4.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset. It has priority over every other control input.
//   bus  : if_stage_if.master
//          inputs  stall, flush, pc_src, branch_target, instr_in
//          outputs instr_addr (same as pc_out, drives the combinational instruction memory),
//                  pc_out, ifid_npc, ifid_instr, ifid_valid
//
// state | meaning
// FILL  | first cycle after reset; IF/ID still holds the reset bubble
// RUN   | normal fetch; stays here until the next reset
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4
) (
   input  logic         clk,
   input  logic         rst,
   if_stage_if.master   bus
);

   typedef enum logic {FILL, RUN} state_t;

   state_t      state_q, state_d;
   logic        run_en;

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;

   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_npc_q,   ifid_npc_d;
   logic        ifid_valid_q, ifid_valid_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= FILL;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      run_en  = 1'b0;
      case (state_q)
         FILL: state_d = RUN;
         RUN: begin
            state_d = RUN;
            run_en  = 1'b1;
         end
         default: state_d = FILL;
      endcase
   end

   // Wraps modulo 2^32. No carry-out is kept.
   assign pc_plus4 = pc_q + PC_STEP;

   // A taken branch wins over stall, so that a redirect is never lost while the
   // front end is frozen.
   always_comb begin
      pc_next = pc_plus4;
      if (bus.pc_src)
         pc_next = bus.branch_target & ~32'h3;
      else if (bus.stall)
         pc_next = pc_q;
   end

   // When stall and flush are both asserted, the bubble wins. The stalled IF/ID contents
   // are dropped in that case.
   always_comb begin
      ifid_instr_d = bus.instr_in;
      ifid_npc_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      if (bus.flush) begin
         ifid_instr_d = NOP_INSTR;
         ifid_npc_d   = 32'h0;
         ifid_valid_d = 1'b0;
      end else if (bus.stall) begin
         ifid_instr_d = ifid_instr_q;
         ifid_npc_d   = ifid_npc_q;
         ifid_valid_d = ifid_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_npc_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_next;
         ifid_instr_q <= ifid_instr_d;
         ifid_npc_q   <= ifid_npc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign bus.instr_addr = pc_q;
   assign bus.pc_out     = pc_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.ifid_npc   = ifid_npc_q;
   // During FILL the register still holds the reset bubble. Gating it here keeps
   // valid low for that whole cycle.
   assign bus.ifid_valid = ifid_valid_q & run_en;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] npc;
      logic        valid;
   } snap_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   snap_t q_a[$];
   snap_t q_b[$];
   snap_t ea, eb;

   // Reference model state. Index 0 is dut_a (RESET_PC 0) and index 1 is dut_b
   // (RESET_PC FFFF_FFF8).
   logic [31:0] m_pc    [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_npc   [2];
   logic        m_valid [2];

   // Instruction memory content as a function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0: return 32'h2008_0005;
         32'h4: return 32'h2009_000A;
         32'h8: return 32'h0109_5020;
         default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      endcase
   endfunction

   function automatic logic [31:0] reset_pc(input int k);
      return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
   endfunction

   if_stage_if bus_a();
   if_stage_if bus_b();

   assign bus_a.instr_in = mem_word(bus_a.instr_addr);
   assign bus_b.instr_in = mem_word(bus_b.instr_addr);

   if_stage #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic chk(input string nm, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
      end
   endtask

   // Applies one cycle of stimulus to both DUTs and pushes the expected post-edge view.
   task automatic cyc(input logic r, input logic s, input logic f, input logic ps,
                      input logic [31:0] t);
      snap_t sn;
      rst = r;
      bus_a.stall = s;  bus_b.stall = s;
      bus_a.flush = f;  bus_b.flush = f;
      bus_a.pc_src = ps; bus_b.pc_src = ps;
      bus_a.branch_target = t; bus_b.branch_target = t;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            m_pc[k] = reset_pc(k); m_instr[k] = 32'h0; m_npc[k] = 32'h0; m_valid[k] = 1'b0;
         end else begin
            if (f) begin
               m_instr[k] = 32'h0; m_npc[k] = 32'h0; m_valid[k] = 1'b0;
            end else if (!s) begin
               m_instr[k] = mem_word(m_pc[k]); m_npc[k] = m_pc[k] + 32'd4; m_valid[k] = 1'b1;
            end
            if (ps)      m_pc[k] = {t[31:2], 2'b00};
            else if (!s) m_pc[k] = m_pc[k] + 32'd4;
         end
         sn = '{pc: m_pc[k], instr: m_instr[k], npc: m_npc[k], valid: m_valid[k]};
         if (k == 0) q_a.push_back(sn);
         else        q_b.push_back(sn);
      end
      @(posedge clk);
      #2;
   endtask

   // Monitor: once per cycle, one expected snapshot per DUT is compared with the DUT outputs.
   always begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         chk("pc_out",     0, bus_a.pc_out,     ea.pc);
         chk("instr_addr", 0, bus_a.instr_addr, ea.pc);
         chk("ifid_instr", 0, bus_a.ifid_instr, ea.instr);
         chk("ifid_npc",   0, bus_a.ifid_npc,   ea.npc);
         chk("ifid_valid", 0, {31'b0, bus_a.ifid_valid}, {31'b0, ea.valid});
      end
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         chk("pc_out",     1, bus_b.pc_out,     eb.pc);
         chk("instr_addr", 1, bus_b.instr_addr, eb.pc);
         chk("ifid_instr", 1, bus_b.ifid_instr, eb.instr);
         chk("ifid_npc",   1, bus_b.ifid_npc,   eb.npc);
         chk("ifid_valid", 1, {31'b0, bus_b.ifid_valid}, {31'b0, eb.valid});
      end
   end

   initial begin
      logic r, s, f, ps;
      // Reset, then sequential fetch.
      cyc(1, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 32'h0);
      // Two stall cycles at pc 8, then release.
      cyc(0, 1, 0, 0, 32'h0);
      cyc(0, 1, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 0, 32'h0);
      // Branch with flush to a misaligned target at pc 0x10.
      cyc(0, 0, 1, 1, 32'h43);
      cyc(0, 0, 0, 0, 32'h0);
      // Stall and flush together.
      cyc(0, 1, 1, 0, 32'h0);
      // Reset that overrides stall and a pending branch. dut_b then wraps past 0.
      cyc(1, 1, 0, 1, 32'h80);
      repeat (4) cyc(0, 0, 0, 0, 32'h0);
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(99) < 2);
         s  = ($urandom_range(99) < 25);
         f  = ($urandom_range(99) < 15);
         ps = ($urandom_range(99) < 15);
         cyc(r, s, f, ps, $urandom());
      end
      chk("drain_a", 0, q_a.size(), 32'd0);
      chk("drain_b", 1, q_b.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
